// File: rtl/downlink_scheduler.sv
// downlink_scheduler: arbitrates the single ground-station downlink between two camera
// buffers, round-robin on ties, and drains the granted buffer until its level reads 0.
// All outputs are registered.
module downlink_scheduler #(
   parameter int unsigned SETUP_CYCLES = 2,  // link handshake cycles, must be >= 1
   parameter int unsigned TIMEOUT      = 64  // stalled XFER cycles before abort
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req1,
   input  logic       req2,
   input  logic [3:0] pct1,
   input  logic [3:0] pct2,
   input  logic       link_up,
   output logic       grant1,
   output logic       grant2,
   output logic       drain1,
   output logic       drain2,
   output logic       done,
   output logic       error,
   output logic [1:0] state,
   output logic [7:0] count
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StSetup = 2'd1;
   localparam logic [1:0] StXfer  = 2'd2;
   localparam logic [1:0] StPause = 2'd3;

   localparam int unsigned SetupW = $clog2(SETUP_CYCLES + 1);
   localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

   logic [1:0]        state_q, state_d;
   logic              sel_q, sel_d;    // 0: camera 1, 1: camera 2
   logic              last_q, last_d;  // camera served last, same encoding as sel
   logic [SetupW-1:0] setup_q, setup_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [3:0]        prev_q, prev_d;  // last observed level of the selected camera
   logic [1:0]        grant_q, grant_d;
   logic [1:0]        drain_q, drain_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [7:0]        count_q, count_d;

   logic [3:0] pct1_c, pct2_c, pct_sel;
   logic [1:0] sel_oh;
   logic       pick;

   // Levels above 10 are out of range for the buffer counters and read as full.
   assign pct1_c  = (pct1 > 4'd10) ? 4'd10 : pct1;
   assign pct2_c  = (pct2 > 4'd10) ? 4'd10 : pct2;
   assign pct_sel = sel_q ? pct2_c : pct1_c;
   assign sel_oh  = sel_q ? 2'b10 : 2'b01;

   // Next-state logic for arbitration, handshake, draining and timeout.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      setup_d = setup_q;
      timer_d = timer_q;
      prev_d  = prev_q;
      grant_d = grant_q;
      drain_d = 2'b00;
      done_d  = 1'b0;
      error_d = 1'b0;
      count_d = count_q;
      pick    = 1'b0;
      case (state_q)
         StIdle: begin
            grant_d = 2'b00;
            if (link_up && (req1 || req2)) begin
               // On a tie the camera not served last wins.
               pick    = (req1 && req2) ? ~last_q : req2;
               sel_d   = pick;
               grant_d = pick ? 2'b10 : 2'b01;
               prev_d  = pick ? pct2_c : pct1_c;
               setup_d = '0;
               timer_d = '0;
               state_d = StSetup;
            end
         end
         StSetup: begin
            if (!link_up) begin
               state_d = StPause;
            end else if (setup_q >= SetupW'(SETUP_CYCLES - 1)) begin
               state_d = StXfer;
            end else begin
               setup_d = setup_q + SetupW'(1);
            end
         end
         StXfer: begin
            if (!link_up) begin
               state_d = StPause;
            end else if (pct_sel == 4'd0) begin
               done_d  = 1'b1;
               grant_d = 2'b00;
               last_d  = sel_q;
               count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
               state_d = StIdle;
            end else if (pct_sel != prev_q) begin
               prev_d  = pct_sel;
               timer_d = '0;
               drain_d = sel_oh;
            end else if (timer_q >= TimerW'(TIMEOUT - 1)) begin
               // Level stuck too long: abandon the transfer without counting it.
               error_d = 1'b1;
               grant_d = 2'b00;
               last_d  = sel_q;
               state_d = StIdle;
            end else begin
               timer_d = timer_q + TimerW'(1);
               drain_d = sel_oh;
            end
         end
         StPause: begin
            // Grant held, drain off, timer frozen until the link returns.
            if (link_up) begin
               state_d = StXfer;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset clears grant/drain immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         sel_q   <= 1'b0;
         last_q  <= 1'b1;
         setup_q <= '0;
         timer_q <= '0;
         prev_q  <= 4'd0;
         grant_q <= 2'b00;
         drain_q <= 2'b00;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         count_q <= 8'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         setup_q <= setup_d;
         timer_q <= timer_d;
         prev_q  <= prev_d;
         grant_q <= grant_d;
         drain_q <= drain_d;
         done_q  <= done_d;
         error_q <= error_d;
         count_q <= count_d;
      end
   end

   assign grant1 = grant_q[0];
   assign grant2 = grant_q[1];
   assign drain1 = drain_q[0];
   assign drain2 = drain_q[1];
   assign done   = done_q;
   assign error  = error_q;
   assign state  = state_q;
   assign count  = count_q;

endmodule

// File: tb/tb_downlink_scheduler.sv
// Bench for downlink_scheduler: transaction-level reference model plus directed scenarios
// with hand-computed edge numbers, then randomized camera/buffer/link traffic.
module tb_downlink_scheduler;
   localparam int unsigned SetupCycles = 2;
   localparam int unsigned Timeout     = 64;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       req1 = 1'b0, req2 = 1'b0, link_up = 1'b0;
   logic [3:0] pct1 = 4'd0, pct2 = 4'd0;
   logic       grant1, grant2, drain1, drain2, done, error;
   logic [1:0] state;
   logic [7:0] count;

   downlink_scheduler #(
      .SETUP_CYCLES(SetupCycles),
      .TIMEOUT     (Timeout)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .req1   (req1),
      .req2   (req2),
      .pct1   (pct1),
      .pct2   (pct2),
      .link_up(link_up),
      .grant1 (grant1),
      .grant2 (grant2),
      .drain1 (drain1),
      .drain2 (drain2),
      .done   (done),
      .error  (error),
      .state  (state),
      .count  (count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: which camera owns the link, what phase the transfer is in.
   int m_phase, m_cam, m_last, m_setup_left, m_stuck, m_seen, m_count;
   int e_drain_cam;
   bit e_done, e_error;

   function automatic int clamp10(input int v);
      return (v > 10) ? 10 : v;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_cam = 0; m_last = 2; m_setup_left = 0;
      m_stuck = 0; m_seen = 0; m_count = 0;
      e_drain_cam = 0; e_done = 1'b0; e_error = 1'b0;
   endtask

   task automatic model_step(input bit r1, input bit r2, input bit lu, input int p1,
                             input int p2);
      int pc;
      e_done = 1'b0; e_error = 1'b0; e_drain_cam = 0;
      pc = (m_cam == 2) ? clamp10(p2) : clamp10(p1);
      case (m_phase)
         0: if (lu && (r1 || r2)) begin
            if (r1 && r2) m_cam = (m_last == 1) ? 2 : 1;
            else m_cam = r1 ? 1 : 2;
            m_seen = (m_cam == 2) ? clamp10(p2) : clamp10(p1);
            m_setup_left = SetupCycles;
            m_stuck = 0;
            m_phase = 1;
         end
         1: if (!lu) m_phase = 3;
            else begin
               m_setup_left--;
               if (m_setup_left == 0) m_phase = 2;
            end
         2: if (!lu) m_phase = 3;
            else if (pc == 0) begin
               e_done = 1'b1;
               if (m_count < 255) m_count++;
               m_last = m_cam; m_cam = 0; m_phase = 0;
            end else begin
               if (pc != m_seen) begin m_seen = pc; m_stuck = 0; end
               else m_stuck++;
               if (m_stuck >= Timeout) begin
                  e_error = 1'b1;
                  m_last = m_cam; m_cam = 0; m_phase = 0;
               end else e_drain_cam = m_cam;
            end
         3: if (lu) m_phase = 2;
         default: m_phase = 0;
      endcase
   endtask

   // Single compare process, away from the active edge.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("grant1", int'(grant1), int'(m_cam == 1));
         chk("grant2", int'(grant2), int'(m_cam == 2));
         chk("drain1", int'(drain1), int'(e_drain_cam == 1));
         chk("drain2", int'(drain2), int'(e_drain_cam == 2));
         chk("done", int'(done), int'(e_done));
         chk("error", int'(error), int'(e_error));
         chk("state", int'(state), m_phase);
         chk("count", int'(count), m_count);
         chk("grant_overlap", int'(grant1 && grant2), 0);
         chk("drain_without_grant", int'((drain1 && !grant1) || (drain2 && !grant2)), 0);
      end
   end

   // Observation bookkeeping, per scenario.
   int edge_n, first_g1_e, first_g2_e, first_d1_e, done_e, err_e;
   int n_done, n_err, n_drain1, n_drain2;
   int order[$];
   bit g1_prev, g2_prev, stuck1, stuck2, rand_en;

   task automatic clear_track();
      edge_n = 0; first_g1_e = -1; first_g2_e = -1; first_d1_e = -1;
      done_e = -1; err_e = -1; n_done = 0; n_err = 0; n_drain1 = 0; n_drain2 = 0;
      order.delete(); g1_prev = 1'b0; g2_prev = 1'b0;
   endtask

   task automatic randomize_inputs();
      if (pct1 == 4'd0 && $urandom_range(15) == 0) begin
         pct1 = 4'($urandom_range(15)); stuck1 = ($urandom_range(9) == 0); req1 = 1'b1;
      end
      if (pct2 == 4'd0 && $urandom_range(15) == 0) begin
         pct2 = 4'($urandom_range(15)); stuck2 = ($urandom_range(9) == 0); req2 = 1'b1;
      end
      if (pct1 == 4'd0 && req1 && $urandom_range(3) == 0) req1 = 1'b0;
      if (pct2 == 4'd0 && req2 && $urandom_range(3) == 0) req2 = 1'b0;
      if ($urandom_range(60) == 0) req1 = ~req1;
      if ($urandom_range(60) == 0) req2 = ~req2;
      if (stuck1 && $urandom_range(99) == 0) stuck1 = 1'b0;
      if (stuck2 && $urandom_range(99) == 0) stuck2 = 1'b0;
      if (link_up ? ($urandom_range(40) == 0) : ($urandom_range(6) == 0)) link_up = ~link_up;
   endtask

   // One clock: model update at the edge, then observe and let the buffers react.
   task automatic cycle();
      bit d1, d2;
      d1 = drain1; d2 = drain2;
      @(posedge clock);
      if (reset) model_reset();
      else model_step(req1, req2, link_up, int'(pct1), int'(pct2));
      edge_n++;
      #1;
      if (grant1 && !g1_prev) begin
         order.push_back(1);
         if (first_g1_e < 0) first_g1_e = edge_n;
      end
      if (grant2 && !g2_prev) begin
         order.push_back(2);
         if (first_g2_e < 0) first_g2_e = edge_n;
      end
      g1_prev = grant1; g2_prev = grant2;
      if (drain1) begin
         n_drain1++;
         if (first_d1_e < 0) first_d1_e = edge_n;
      end
      if (drain2) n_drain2++;
      if (done) begin n_done++; done_e = edge_n; end
      if (error) begin n_err++; err_e = edge_n; end
      if (d1 && !stuck1 && pct1 != 4'd0) pct1 = (pct1 > 4'd10) ? 4'd9 : pct1 - 4'd1;
      if (d2 && !stuck2 && pct2 != 4'd0) pct2 = (pct2 > 4'd10) ? 4'd9 : pct2 - 4'd1;
      if (rand_en) randomize_inputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      req1 = 1'b0; req2 = 1'b0; pct1 = 4'd0; pct2 = 4'd0; link_up = 1'b0;
      stuck1 = 1'b0; stuck2 = 1'b0; rand_en = 1'b0;
      repeat (2) cycle();
      reset = 1'b0;
      clear_track();
   endtask

   task automatic run_until_done(input int target, input int budget, input string name);
      int k = 0;
      while (n_done < target && k < budget) begin cycle(); k++; end
      chk(name, int'(n_done >= target), 1);
   endtask

   task automatic run_until_err(input int target, input int budget, input string name);
      int k = 0;
      while (n_err < target && k < budget) begin cycle(); k++; end
      chk(name, int'(n_err >= target), 1);
   endtask

   initial begin
      #1;
      reset = 1'b1;
      model_reset();
      chk_en = 1'b1;
      do_reset();
      chk("reset_state", int'(state), 0);
      chk("reset_count", int'(count), 0);
      chk("reset_grants", int'({grant1, grant2}), 0);

      // Single request, level 9.
      req1 = 1'b1; pct1 = 4'd9; link_up = 1'b1;
      run_until_done(1, 40, "A_wait_done");
      req1 = 1'b0;
      chk("A_grant_edge", first_g1_e, 1);
      chk("A_first_drain_edge", first_d1_e, 4);
      chk("A_done_edge", done_e, 14);
      chk("A_count", int'(count), 1);
      chk("A_grant2_never", first_g2_e, -1);
      chk("A_drain2_never", n_drain2, 0);

      // Tie from reset, then round-robin.
      do_reset();
      req1 = 1'b1; req2 = 1'b1; pct1 = 4'd3; pct2 = 4'd3; link_up = 1'b1;
      for (int k = 0; k < 200 && n_done < 3; k++) begin
         cycle();
         if (done && order.size() > 0) begin
            if (order[$] == 1) pct1 = 4'd3;
            else pct2 = 4'd3;
         end
      end
      req1 = 1'b0; req2 = 1'b0;
      chk("B_grants_seen", order.size(), 3);
      chk("B_first", (order.size() > 0) ? order[0] : 0, 1);
      chk("B_second", (order.size() > 1) ? order[1] : 0, 2);
      chk("B_third", (order.size() > 2) ? order[2] : 0, 1);
      chk("B_count", int'(count), 3);

      // Link loss for 10 cycles in XFER.
      do_reset();
      req1 = 1'b1; pct1 = 4'd5; link_up = 1'b1;
      repeat (3) cycle();
      chk("C_in_xfer", int'(state), 2);
      link_up = 1'b0;
      repeat (10) cycle();
      chk("C_pause_state", int'(state), 3);
      chk("C_pct_held", int'(pct1), 5);
      chk("C_grant_held", int'(grant1), 1);
      chk("C_drain_off", int'(drain1), 0);
      link_up = 1'b1;
      run_until_done(1, 30, "C_wait_done");
      req1 = 1'b0;
      chk("C_done_edge", done_e, 21);
      chk("C_no_error", n_err, 0);

      // Timeout on a stuck camera-2 buffer; camera 1 waits meanwhile.
      do_reset();
      req2 = 1'b1; pct2 = 4'd7; stuck2 = 1'b1; link_up = 1'b1;
      repeat (5) cycle();
      req1 = 1'b1; pct1 = 4'd2;
      run_until_err(1, 100, "D_wait_error");
      chk("D_error_edge", err_e, 67);
      chk("D_count_unchanged", int'(count), 0);
      chk("D_grant2_dropped", int'(grant2), 0);
      cycle();
      chk("D_next_grant_cam1", first_g1_e, 68);
      req2 = 1'b0; stuck2 = 1'b0;
      run_until_done(1, 40, "D_wait_cam1_done");
      req1 = 1'b0;
      chk("D_count_after", int'(count), 1);

      // Out-of-range level drains like 10; empty buffer completes without draining.
      do_reset();
      req1 = 1'b1; pct1 = 4'd15; link_up = 1'b1;
      run_until_done(1, 40, "E_wait_done_15");
      req1 = 1'b0;
      chk("E_done_edge_15", done_e, 15);
      chk("E_drain_cycles_15", n_drain1, 11);
      do_reset();
      req1 = 1'b1; pct1 = 4'd0; link_up = 1'b1;
      run_until_done(1, 20, "E_wait_done_0");
      req1 = 1'b0;
      chk("E_done_edge_0", done_e, 4);
      chk("E_drain_cycles_0", n_drain1, 0);
      chk("E_count_0", int'(count), 1);

      // Asynchronous reset in the middle of a camera-2 transfer.
      do_reset();
      req1 = 1'b1; pct1 = 4'd1; link_up = 1'b1;
      run_until_done(1, 30, "F_wait_first_done");
      req1 = 1'b0; req2 = 1'b1; pct2 = 4'd8;
      repeat (5) cycle();
      chk("F_pre_grant2", int'(grant2), 1);
      chk("F_pre_drain2", int'(drain2), 1);
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      chk("F_grant2_cleared", int'(grant2), 0);
      chk("F_drain2_cleared", int'(drain2), 0);
      chk("F_state_cleared", int'(state), 0);
      chk("F_count_cleared", int'(count), 0);
      repeat (2) cycle();
      reset = 1'b0;
      clear_track();
      req1 = 1'b1; req2 = 1'b1; pct1 = 4'd2;
      cycle();
      chk("F_tie_grant1", int'(grant1), 1);
      chk("F_tie_grant2", int'(grant2), 0);
      req1 = 1'b0; req2 = 1'b0;
      run_until_done(1, 40, "F_wait_done");

      // Randomized traffic against the model.
      do_reset();
      link_up = 1'b1;
      rand_en = 1'b1;
      repeat (4000) cycle();
      rand_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
